// File: rtl/led_fade_pwm.sv
// led_fade_pwm: per-channel LED fader. Each channel's level ramps toward a
// latched target by one step per tick_in strobe. The levels are turned into
// glitch-free PWM with a 255-cycle period.
// Optional feature macro: LED_FADE_GAMMA_EN. When it is defined, the PWM duty
// is the square-law gamma of the level instead of the level itself.
module led_fade_pwm #(
    parameter int CH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick_in,
    input  logic [8*CH-1:0] target,
    input  logic            target_valid,
    output logic            target_ready,
    output logic            busy,
    output logic [CH-1:0]   led
);

    localparam logic [7:0] PWM_LAST = 8'd254;

    typedef enum logic {
        IDLE,
        FADE
    } state_t;

    state_t     state;
    logic [7:0] pwm_cnt;
    logic [7:0] level [CH];
    logic [7:0] tgt   [CH];
    logic [7:0] duty  [CH];
    logic       all_eq;
    logic       period_end;

    assign period_end = (pwm_cnt == PWM_LAST);

`ifdef LED_FADE_GAMMA_EN
    // Perceptual correction: (l*l + 255) >> 8 keeps 0->0, 1->1 and 255->255.
    function automatic logic [7:0] duty_of(input logic [7:0] lvl);
        logic [15:0] sq;
        sq = 16'(lvl) * 16'(lvl) + 16'd255;
        return sq[15:8];
    endfunction
`else
    // Linear brightness: the duty is the level itself.
    function automatic logic [7:0] duty_of(input logic [7:0] lvl);
        return lvl;
    endfunction
`endif

    // Fade is complete when every registered level matches its target.
    // NOTE: each combinational output gets a default before any condition, so no latch can be inferred.
    always_comb begin
        all_eq = 1'b1;
        for (int i = 0; i < CH; i++) begin
            if (level[i] != tgt[i]) begin
                all_eq = 1'b0;
            end
        end
    end

    // Free-running PWM phase counter that counts 0..254 and then wraps.
    // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else if (period_end) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    // The duty shadow updates only at a period boundary, so a pulse is never truncated.
    // The LED pin is a registered compare against the duty.
    // NOTE: these small per-channel arrays are reset explicitly because their contents are visible on led.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                duty[i] <= '0;
            end
            led <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (period_end) begin
                    duty[i] <= duty_of(level[i]);
                end
                led[i] <= (pwm_cnt < duty[i]);
            end
        end
    end

    // Handshake and fade FSM with registered ready/busy outputs.
    // A step moves a level one count toward its target and never passes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            target_ready <= 1'b1;
            busy         <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                level[i] <= '0;
                tgt[i]   <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (target_valid && target_ready) begin
                        for (int i = 0; i < CH; i++) begin
                            tgt[i] <= target[8*i +: 8];
                        end
                        state        <= FADE;
                        target_ready <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                FADE: begin
                    if (tick_in) begin
                        for (int i = 0; i < CH; i++) begin
                            if (level[i] < tgt[i]) begin
                                level[i] <= level[i] + 8'd1;
                            end else if (level[i] > tgt[i]) begin
                                level[i] <= level[i] - 8'd1;
                            end
                        end
                    end
                    if (all_eq) begin
                        state        <= IDLE;
                        target_ready <= 1'b1;
                        busy         <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    target_ready <= 1'b1;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_fade_pwm.sv
// tb_led_fade_pwm: self-checking bench for led_fade_pwm (CH = 8).
// The expected brightness of each channel is derived from the fade rules.
// Each fade must end on its target, take max-distance ticks, and produce
// duty high cycles per 255-cycle window.
`timescale 1ns/1ps
module tb_led_fade_pwm;

    localparam int CH     = 8;
    localparam int PERIOD = 255;

    logic            clk = 1'b0;
    logic            rst;
    logic            tick_in;
    logic [8*CH-1:0] target;
    logic            target_valid;
    logic            target_ready;
    logic            busy;
    logic [CH-1:0]   led;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the settled brightness level of each channel.
    int model_level [CH];

    typedef struct {
        logic [8*CH-1:0] tgt;
        int              gap;          // idle cycles between ticks
        bit              accept_tick;  // tick_in high in the accept cycle
        int              exp_ticks;
    } vec_t;

    vec_t vecs [6];

    led_fade_pwm #(.CH(CH)) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_in      (tick_in),
        .target       (target),
        .target_valid (target_valid),
        .target_ready (target_ready),
        .busy         (busy),
        .led          (led)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int duty_ref(input int l);
`ifdef LED_FADE_GAMMA_EN
        return (l * l + 255) / 256;
`else
        return l;
`endif
    endfunction

    function automatic int max_dist(input logic [8*CH-1:0] w);
        int d;
        int m;
        m = 0;
        for (int i = 0; i < CH; i++) begin
            d = int'(w[8*i +: 8]) - model_level[i];
            if (d < 0) d = -d;
            if (d > m) m = d;
        end
        return m;
    endfunction

    task automatic set_model(input logic [8*CH-1:0] w);
        for (int i = 0; i < CH; i++) model_level[i] = int'(w[8*i +: 8]);
    endtask

    // Offer one target, drive exp_ticks ticks and check that busy covers exactly that fade.
    task automatic run_fade(input string tag, input logic [8*CH-1:0] w, input int gap,
                            input bit accept_tick, input int exp_ticks);
        int bad;
        check({tag, " ready_before_offer"}, target_ready, 1);
        target       = w;
        target_valid = 1'b1;
        tick_in      = accept_tick;
        step();
        target_valid = 1'b0;
        target       = {$urandom, $urandom};
        check({tag, " busy_ready_after_accept"}, {busy, target_ready}, 2'b10);
        bad = 0;
        for (int k = 0; k < exp_ticks; k++) begin
            if (k > 0) begin
                repeat (gap) begin
                    tick_in = 1'b0;
                    step();
                    if (!busy || target_ready) bad++;
                end
            end
            tick_in = 1'b1;
            step();
            if (!busy || target_ready) bad++;
        end
        tick_in = 1'b0;
        step();
        check({tag, " busy_lost_mid_fade"}, bad, 0);
        check({tag, " idle_after_last_step"}, {busy, target_ready}, 2'b01);
        set_model(w);
    endtask

    // Let the new level reach the duty shadow, then count LED high cycles over one period.
    task automatic check_duty(input string tag);
        int highs [CH];
        int bad;
        bad = 0;
        repeat (260) begin
            tick_in = 1'($urandom);
            step();
            if (busy || !target_ready) bad++;
        end
        for (int i = 0; i < CH; i++) highs[i] = 0;
        repeat (PERIOD) begin
            tick_in = 1'($urandom);
            step();
            if (busy || !target_ready) bad++;
            for (int i = 0; i < CH; i++) highs[i] += int'(led[i]);
        end
        tick_in = 1'b0;
        check({tag, " idle_ticks_ignored"}, bad, 0);
        for (int i = 0; i < CH; i++) begin
            check($sformatf("%s led%0d_high_cycles", tag, i), highs[i], duty_ref(model_level[i]));
        end
    endtask

    initial begin
        logic [8*CH-1:0] word_a;
        logic [8*CH-1:0] word_b;
        logic [8*CH-1:0] rnd;
        int              d_a;
        int              bad_led;
        int              bad_hs;
        int              bad;

        vecs[0] = '{tgt: {8{8'h10}}, gap: 3, accept_tick: 1'b0, exp_ticks: 16};
        vecs[1] = '{tgt: {8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h00, 8'h20},
                    gap: 0, accept_tick: 1'b1, exp_ticks: 16};
        vecs[2] = '{tgt: {8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h03, 8'h1C},
                    gap: 3, accept_tick: 1'b0, exp_ticks: 4};
        vecs[3] = '{tgt: {8{8'hFF}}, gap: 0, accept_tick: 1'b1, exp_ticks: 252};
        vecs[4] = '{tgt: {8{8'hFF}}, gap: 0, accept_tick: 1'b1, exp_ticks: 0};
        vecs[5] = '{tgt: {8'hFF, 8'h80, 8'h40, 8'h02, 8'h01, 8'h00, 8'h7F, 8'hFE},
                    gap: 1, accept_tick: 1'b0, exp_ticks: 255};

        rst          = 1'b1;
        tick_in      = 1'b0;
        target       = '0;
        target_valid = 1'b0;
        for (int i = 0; i < CH; i++) model_level[i] = 0;

        // Reset for three cycles, then stay idle with no targets.
        repeat (3) step();
        check("reset led", led, 0);
        check("reset ready", target_ready, 1);
        check("reset busy", busy, 0);
        rst = 1'b0;
        bad_led = 0;
        bad_hs  = 0;
        repeat (600) begin
            step();
            if (led != '0) bad_led++;
            if (!target_ready || busy) bad_hs++;
        end
        check("idle led_nonzero_cycles", bad_led, 0);
        check("idle handshake_bad_cycles", bad_hs, 0);

        // Directed table: ramp, mixed direction, extremes, no-op, gamma points.
        for (int v = 0; v < 6; v++) begin
            run_fade($sformatf("vec%0d", v), vecs[v].tgt, vecs[v].gap,
                     vecs[v].accept_tick, vecs[v].exp_ticks);
            check_duty($sformatf("vec%0d", v));
        end

        // Random targets and tick spacing against the level model.
        for (int t = 0; t < 6; t++) begin
            rnd = {$urandom, $urandom};
            run_fade($sformatf("rnd%0d", t), rnd, int'($urandom_range(0, 3)),
                     1'($urandom), max_dist(rnd));
            check_duty($sformatf("rnd%0d", t));
        end

        // Backpressure: the second word is held until the first ready cycle.
        word_a = {8{8'h30}};
        word_b = {8{8'h70}};
        d_a    = max_dist(word_a);
        check("bp ready_before_offer", target_ready, 1);
        target       = word_a;
        target_valid = 1'b1;
        tick_in      = 1'b0;
        step();
        target  = word_b;
        tick_in = 1'b1;
        bad     = 0;
        for (int k = 0; k < d_a; k++) begin
            step();
            if (target_ready || !busy) bad++;
        end
        tick_in = 1'b0;
        step();
        check("bp held_off_during_fade", bad, 0);
        check("bp idle_after_first_fade", {busy, target_ready}, 2'b01);
        step();
        check("bp second_word_accepted", {busy, target_ready}, 2'b10);
        target_valid = 1'b0;
        set_model(word_a);

        // Reset in the middle of the second fade.
        tick_in = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        check("midreset led", led, 0);
        check("midreset ready", target_ready, 1);
        check("midreset busy", busy, 0);
        rst     = 1'b0;
        tick_in = 1'b0;
        for (int i = 0; i < CH; i++) model_level[i] = 0;
        bad_led = 0;
        repeat (300) begin
            step();
            if (led != '0) bad_led++;
        end
        check("midreset led_stays_off", bad_led, 0);

        // Recovery from reset with a short fade.
        run_fade("post_reset", {8{8'h05}}, 1, 1'b0, 5);
        check_duty("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
